// File: rtl/ext_dev_pkg.sv
// Shared types, default parameters and the block word pattern for external_dma_device.
package ext_dev_pkg;

    typedef enum logic [1:0] {
        COUNTDOWN = 2'd0,
        PENDING   = 2'd1,
        SERVE     = 2'd2
    } dev_state_e;

    localparam int DEF_WORD_SIZE     = 16;
    localparam int DEF_BLOCK_LEN     = 12;
    localparam int DEF_BURST_LEN     = 4;
    localparam int DEF_TRIGGER_DELAY = 64;
    localparam int DEF_REARM_DELAY   = 32;
    localparam int DEF_READ_LATENCY  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Word idx of block gen: upper half is the block generation, lower half the index.
    function automatic logic [63:0] pattern_word(input int unsigned word_size,
                                                 input logic [63:0] gen,
                                                 input int unsigned idx);
        logic [63:0] mask;
        mask = (64'd1 << (word_size / 2)) - 64'd1;
        return ((gen & mask) << (word_size / 2)) | (64'(idx) & mask);
    endfunction

endpackage

// File: rtl/external_dma_device_if.sv
// Device data bus between the CPU/DMA side (master) and external_dma_device (slave).
interface external_dma_device_if
    import ext_dev_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int BURST_LEN = DEF_BURST_LEN
) ();

    logic                           int_ack;
    logic                           rd_req;
    logic [WORD_SIZE-1:0]           offset;
    logic                           interrupt;
    logic [BURST_LEN*WORD_SIZE-1:0] data;
    logic                           data_valid;
    logic                           rd_err;
    logic                           busy;

    modport master (
        output int_ack, rd_req, offset,
        input  interrupt, data, data_valid, rd_err, busy
    );

    modport slave (
        input  int_ack, rd_req, offset,
        output interrupt, data, data_valid, rd_err, busy
    );

endinterface

// File: rtl/ext_dev_timer.sv
// Reloadable down-counter that halts at zero; count is exposed for debug.
module ext_dev_timer #(
    parameter int             CNT_W       = 7,
    parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= RESET_VALUE;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero  = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/external_dma_device.sv
// Peripheral that fills a block, interrupts, then serves fixed-latency burst reads.
// Build option: EXTDEV_TRISTATE_EN floats data while idle instead of driving zeros.
module external_dma_device
    import ext_dev_pkg::*;
#(
    parameter int WORD_SIZE     = DEF_WORD_SIZE,
    parameter int BLOCK_LEN     = DEF_BLOCK_LEN,
    parameter int BURST_LEN     = DEF_BURST_LEN,
    parameter int TRIGGER_DELAY = DEF_TRIGGER_DELAY,
    parameter int REARM_DELAY   = DEF_REARM_DELAY,
    parameter int READ_LATENCY  = DEF_READ_LATENCY
) (
    input  logic clk,
    input  logic reset_n,
    external_dma_device_if.slave bus
);

    localparam int CNT_W  = $clog2(max_int(TRIGGER_DELAY, REARM_DELAY) + 1);
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);
    localparam int GEN_W  = WORD_SIZE / 2;
    localparam int IDX_W  = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam int DATA_W = BURST_LEN * WORD_SIZE;

    dev_state_e           state_reg, state_next;
    logic [GEN_W-1:0]     gen_count_reg;
    logic                 interrupt_reg, interrupt_next;
    logic [WORD_SIZE-1:0] buf_reg [BLOCK_LEN];
    logic [WORD_SIZE-1:0] load_word [BLOCK_LEN];

    logic                 busy_reg;
    logic [LAT_W-1:0]     lat_cnt_reg;
    logic [WORD_SIZE-1:0] off_reg;
    logic                 ok_reg;
    logic                 last_reg;
    logic                 data_valid_reg;
    logic                 rd_err_reg;
    logic [DATA_W-1:0]    data_reg;
    logic [DATA_W-1:0]    burst_bus;

    logic                 timer_zero;
    logic                 timer_load;
    logic [CNT_W-1:0]     timer_load_value;
    logic [CNT_W-1:0]     dbg_count_unused;
    logic                 buf_load;
    logic                 gen_advance;

    logic                 accept;
    logic                 fire;
    logic                 complete;
    logic [WORD_SIZE:0]   end_sum;

    ext_dev_timer #(
        .CNT_W       (CNT_W),
        .RESET_VALUE (CNT_W'(TRIGGER_DELAY))
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (state_reg == COUNTDOWN),
        .load       (timer_load),
        .load_value (timer_load_value),
        .zero       (timer_zero),
        .count      (dbg_count_unused)
    );

    // Extra top bit keeps offset + BURST_LEN from wrapping near the top of the word range.
    assign end_sum  = {1'b0, bus.offset} + (WORD_SIZE + 1)'(BURST_LEN);
    assign accept   = bus.rd_req && !busy_reg;
    assign fire     = busy_reg && (lat_cnt_reg == '0);
    assign complete = fire && ok_reg && last_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= COUNTDOWN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COUNTDOWN: if (timer_zero)  state_next = PENDING;
            PENDING:   if (bus.int_ack) state_next = SERVE;
            SERVE:     if (complete)    state_next = COUNTDOWN;
            default:                    state_next = COUNTDOWN;
        endcase
    end

    always_comb begin
        interrupt_next   = interrupt_reg;
        timer_load       = 1'b0;
        timer_load_value = CNT_W'(REARM_DELAY);
        buf_load         = 1'b0;
        gen_advance      = 1'b0;
        case (state_reg)
            COUNTDOWN: begin
                if (timer_zero) begin
                    buf_load       = 1'b1;
                    interrupt_next = 1'b1;
                end
            end
            PENDING: begin
                if (bus.int_ack) interrupt_next = 1'b0;
            end
            SERVE: begin
                if (complete) begin
                    timer_load  = 1'b1;
                    gen_advance = 1'b1;
                end
            end
            default: interrupt_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            interrupt_reg <= 1'b0;
            gen_count_reg <= '0;
        end else begin
            interrupt_reg <= interrupt_next;
            if (gen_advance) gen_count_reg <= gen_count_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_LEN; gi++) begin : g_load
            assign load_word[gi] = WORD_SIZE'(pattern_word(WORD_SIZE, 64'(gen_count_reg), gi));
        end

        // Word at offset lands in the MSBs of the burst.
        for (gi = 0; gi < BURST_LEN; gi++) begin : g_burst
            logic [WORD_SIZE-1:0] idx_full;
            assign idx_full = off_reg + WORD_SIZE'(gi);
            assign burst_bus[(BURST_LEN-1-gi)*WORD_SIZE +: WORD_SIZE] =
                (idx_full < WORD_SIZE'(BLOCK_LEN)) ? buf_reg[idx_full[IDX_W-1:0]] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (buf_load) begin
            for (int i = 0; i < BLOCK_LEN; i++) begin
                buf_reg[i] <= load_word[i];
            end
        end
    end

    // busy drops on the response edge, so a request in that same cycle is still refused.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg       <= 1'b0;
            lat_cnt_reg    <= '0;
            off_reg        <= '0;
            ok_reg         <= 1'b0;
            last_reg       <= 1'b0;
            data_valid_reg <= 1'b0;
            rd_err_reg     <= 1'b0;
            data_reg       <= '0;
        end else begin
            data_valid_reg <= fire && ok_reg;
            rd_err_reg     <= fire && !ok_reg;
            data_reg       <= (fire && ok_reg) ? burst_bus : '0;
            if (accept) begin
                busy_reg    <= 1'b1;
                lat_cnt_reg <= LAT_W'(READ_LATENCY - 1);
                off_reg     <= bus.offset;
                ok_reg      <= (state_reg == SERVE) &&
                               (end_sum <= (WORD_SIZE + 1)'(BLOCK_LEN));
                last_reg    <= (end_sum == (WORD_SIZE + 1)'(BLOCK_LEN));
            end else if (fire) begin
                busy_reg    <= 1'b0;
            end else if (busy_reg) begin
                lat_cnt_reg <= lat_cnt_reg - 1'b1;
            end
        end
    end

    assign bus.interrupt  = interrupt_reg;
    assign bus.data_valid = data_valid_reg;
    assign bus.rd_err     = rd_err_reg;
    assign bus.busy       = busy_reg;

`ifdef EXTDEV_TRISTATE_EN
    assign bus.data = data_valid_reg ? data_reg : {DATA_W{1'bz}};
`else
    assign bus.data = data_reg;
`endif

endmodule

// File: tb/tb_external_dma_device.sv
// Directed self-checking bench for external_dma_device at default parameters.
module tb_external_dma_device;
    import ext_dev_pkg::*;

    logic clk;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

`ifdef EXTDEV_TRISTATE_EN
    localparam logic [63:0] IDLE = {64{1'bz}};
`else
    localparam logic [63:0] IDLE = 64'h0;
`endif

    external_dma_device_if #(.WORD_SIZE(16), .BURST_LEN(4)) bus ();

    external_dma_device dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits n edges; interrupt must stay low until exactly the n-th edge.
    task automatic wait_interrupt(input string tag, input int n);
        for (int e = 1; e <= n; e++) begin
            tick();
            check({tag, "_int"}, 64'(bus.interrupt), 64'(e == n));
            check({tag, "_idle"}, {62'd0, bus.data_valid, bus.rd_err}, 64'd0);
            check({tag, "_data"}, bus.data, IDLE);
        end
        $display("interrupt %s after %0d edges", tag, n);
    endtask

    task automatic do_ack(input string tag);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        check({tag, "_ack"}, 64'(bus.interrupt), 64'd0);
    endtask

    task automatic do_read(input string tag, input int off, input logic exp_ok,
                           input logic [63:0] exp_data);
        bus.rd_req = 1'b1;
        bus.offset = 16'(off);
        tick();
        bus.rd_req = 1'b0;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        tick();
        check({tag, "_early"}, {62'd0, bus.data_valid, bus.rd_err}, 64'd0);
        tick();
        check({tag, "_dv"}, 64'(bus.data_valid), 64'(exp_ok));
        check({tag, "_err"}, 64'(bus.rd_err), 64'(!exp_ok));
        check({tag, "_data"}, bus.data, exp_ok ? exp_data : IDLE);
        check({tag, "_free"}, 64'(bus.busy), 64'd0);
        $display("read %s off=%0d dv=%0b err=%0b data=%h", tag, off, bus.data_valid,
                 bus.rd_err, bus.data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_burst;
        logic [63:0] pw;

        bus.int_ack = 1'b0;
        bus.rd_req  = 1'b0;
        bus.offset  = '0;
        reset_n     = 1'b0;
        tick();
        tick();
        check("rst_int",  64'(bus.interrupt),  64'd0);
        check("rst_dv",   64'(bus.data_valid), 64'd0);
        check("rst_err",  64'(bus.rd_err),     64'd0);
        check("rst_busy", 64'(bus.busy),       64'd0);
        check("rst_data", bus.data,            IDLE);
        reset_n = 1'b1;

        wait_interrupt("trig", 65);
        do_ack("blk0");
        do_read("rd0",   0, 1'b1, 64'h0000_0001_0002_0003);
        do_read("rd4",   4, 1'b1, 64'h0004_0005_0006_0007);
        do_read("err10", 10, 1'b0, 64'h0);
        do_read("rd8",   8, 1'b1, 64'h0008_0009_000a_000b);
        wait_interrupt("rearm", 33);

        // Block 1 is pending: reads are refused and the interrupt stays up.
        do_read("pend", 0, 1'b0, 64'h0);
        check("pend_int", 64'(bus.interrupt), 64'd1);
        do_ack("blk1");
        do_read("g1rd0", 0, 1'b1, 64'h0100_0101_0102_0103);
        exp_burst = '0;
        for (int i = 0; i < 4; i++) begin
            pw = pattern_word(16, 64'd1, 4 + i);
            exp_burst = (exp_burst << 16) | {48'd0, pw[15:0]};
        end
        do_read("g1rd4", 4, 1'b1, exp_burst);

        // Requests while busy are dropped; the offset-0 retry must not be answered.
        bus.rd_req = 1'b1;
        bus.offset = 16'd4;
        tick();
        bus.offset = 16'd0;
        tick();
        check("drop_busy", 64'(bus.busy), 64'd1);
        tick();
        bus.rd_req = 1'b0;
        check("drop_dv",   64'(bus.data_valid), 64'd1);
        check("drop_data", bus.data, 64'h0104_0105_0106_0107);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("drop_none", {62'd0, bus.data_valid, bus.rd_err}, 64'd0);
        end
        check("drop_idle", 64'(bus.busy), 64'd0);
        $display("busy drop: two extra requests ignored");

        // Reset in the middle of a final-burst read of block 1.
        bus.rd_req = 1'b1;
        bus.offset = 16'd8;
        tick();
        bus.rd_req = 1'b0;
        check("mid_busy", 64'(bus.busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_rst_out", {61'd0, bus.interrupt, bus.data_valid, bus.rd_err}, 64'd0);
        end
        reset_n = 1'b1;
        wait_interrupt("rerst", 65);
        do_ack("blk0b");
        do_read("rst_rd0", 0, 1'b1, 64'h0000_0001_0002_0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
